// File: rtl/axil_adder_multi.sv
`default_nettype none
// ============================================================================
// Module   : axil_adder_multi
// Brief    : AXI4-Lite slave exposing NUM_CH add/sub channels with flags
// Revision : 1.0 - initial release
// ============================================================================
module axil_adder_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int                    STRB_W      = DATA_WIDTH / 8;
  localparam int                    MSB         = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] ONE_D       = DATA_WIDTH'(1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_WAIT   = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_e;

  wr_state_e wr_state_q, wr_state_d;

  // Holds every ready low until the first edge after reset is released
  logic                    live_q;
  logic                    aw_lat_q, w_lat_q;
  logic [ADDR_WIDTH-3:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [1:0]              bresp_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   opa_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   opb_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   res_q [NUM_CH];
  logic [NUM_CH-1:0]       sub_q, carry_q, ovf_q, done_q, go_q;

  logic [DATA_WIDTH-1:0]   w_res [NUM_CH];
  logic [NUM_CH-1:0]       w_cy, w_ov;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [31:0]             w_wch, w_rch;
  logic [1:0]              w_woff, w_roff;
  logic                    w_wch_ok, w_rch_ok, w_werr;
  logic [DATA_WIDTH-1:0]   w_rd_val;
  logic                    w_unused;

  assign w_unused = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

  assign s1_axi_awready = live_q & (wr_state_q == WR_WAIT) & ~aw_lat_q;
  assign s1_axi_wready  = live_q & (wr_state_q == WR_WAIT) & ~w_lat_q;
  assign s1_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = live_q & ~rvalid_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rresp   = rresp_q;
  assign s1_axi_rdata   = rdata_q;

  assign w_aw_hs  = s1_axi_awvalid & s1_axi_awready;
  assign w_w_hs   = s1_axi_wvalid & s1_axi_wready;
  assign w_ar_hs  = s1_axi_arvalid & s1_axi_arready;
  assign w_commit = (wr_state_q == WR_COMMIT);

  assign w_wch    = 32'(awaddr_q[ADDR_WIDTH-3:2]);
  assign w_woff   = awaddr_q[1:0];
  assign w_wch_ok = (w_wch < 32'(NUM_CH));
  assign w_werr   = ~w_wch_ok | (w_woff == 2'd2);

  assign w_rch    = 32'(s1_axi_araddr[ADDR_WIDTH-1:4]);
  assign w_roff   = s1_axi_araddr[3:2];
  assign w_rch_ok = (w_rch < 32'(NUM_CH));

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] m;
    m = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) m[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return m;
  endfunction

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      wr_state_q <= WR_WAIT;
      live_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      live_q     <= 1'b1;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_WAIT:   if ((aw_lat_q | w_aw_hs) && (w_lat_q | w_w_hs)) wr_state_d = WR_COMMIT;
      WR_COMMIT: wr_state_d = WR_RESP;
      WR_RESP:   if (s1_axi_bready) wr_state_d = WR_WAIT;
      default:   wr_state_d = WR_WAIT;
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        aw_lat_q <= 1'b1;
        awaddr_q <= s1_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        w_lat_q <= 1'b1;
        wdata_q <= s1_axi_wdata;
        wstrb_q <= s1_axi_wstrb;
      end
      if (w_commit) begin
        aw_lat_q <= 1'b0;
        w_lat_q  <= 1'b0;
        bresp_q  <= w_werr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ----------------------------------------------------------- channel compute
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH:0]   w_full;
    logic [DATA_WIDTH-1:0] w_bp;
    assign w_bp     = sub_q[g] ? (~opb_q[g] + ONE_D) : opb_q[g];
    // Bit DATA_WIDTH of the difference is the borrow (A < B unsigned)
    assign w_full   = sub_q[g] ? ({1'b0, opa_q[g]} - {1'b0, opb_q[g]})
                               : ({1'b0, opa_q[g]} + {1'b0, opb_q[g]});
    assign w_res[g] = w_full[DATA_WIDTH-1:0];
    assign w_cy[g]  = w_full[DATA_WIDTH];
    assign w_ov[g]  = (opa_q[g][MSB] == w_bp[MSB]) && (w_full[MSB] != opa_q[g][MSB]);
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        opa_q[c] <= '0;
        opb_q[c] <= '0;
        res_q[c] <= '0;
      end
      sub_q   <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      done_q  <= '0;
      go_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        go_q[c] <= 1'b0;
        if (go_q[c]) begin
          res_q[c]   <= w_res[c];
          carry_q[c] <= w_cy[c];
          ovf_q[c]   <= w_ov[c];
          done_q[c]  <= 1'b1;
        end
        if (w_commit && !w_werr && (w_wch == 32'(c))) begin
          case (w_woff)
            2'd0: if (|wstrb_q) begin
              opa_q[c]  <= merge_bytes(opa_q[c], wdata_q, wstrb_q);
              done_q[c] <= 1'b0;
            end
            2'd1: if (|wstrb_q) begin
              opb_q[c] <= merge_bytes(opb_q[c], wdata_q, wstrb_q);
              go_q[c]  <= 1'b1;
            end
            2'd3: if (wstrb_q[0]) begin
              sub_q[c]  <= wdata_q[0];
              done_q[c] <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------- read path
  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rch == 32'(c)) begin
        case (w_roff)
          2'd0:    w_rd_val = opa_q[c];
          2'd1:    w_rd_val = opb_q[c];
          2'd2:    w_rd_val = res_q[c];
          default: w_rd_val = DATA_WIDTH'({done_q[c], ovf_q[c], carry_q[c], sub_q[c]});
        endcase
      end
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (w_ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= w_rch_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= w_rch_ok ? w_rd_val : '0;
    end else if (rvalid_q && s1_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_adder_multi.sv
`default_nettype none
// Scoreboard bench for axil_adder_multi: directed scenarios plus random traffic
// checked against an arithmetic reference model.
module tb_axil_adder_multi;

  localparam int     DW   = 32;
  localparam int     AW   = 8;
  localparam int     NCH  = 4;
  localparam longint M32  = 64'sd4294967296;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  logic [31:0] m_opa [NCH];
  logic [31:0] m_opb [NCH];
  logic [31:0] m_res [NCH];
  bit          m_sub [NCH];
  bit          m_cy  [NCH];
  bit          m_ov  [NCH];
  bit          m_done[NCH];

  axil_adder_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) dut (
    .s1_axi_aclk(clk), .s1_axi_areset(rst),
    .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
    .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
    .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
    .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
    .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ------------------------------------------------------------ reference model
  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_opa[c] = '0; m_opb[c] = '0; m_res[c] = '0;
      m_sub[c] = 0; m_cy[c] = 0; m_ov[c] = 0; m_done[c] = 0;
    end
  endfunction

  function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  function automatic void model_compute(int ch);
    longint ua, ub, bpv, sum, sa, sbp, ssum;
    ua = longint'(m_opa[ch]);
    ub = longint'(m_opb[ch]);
    if (m_sub[ch]) begin
      sum = ua - ub;  m_cy[ch] = (ua < ub);  bpv = (M32 - ub) % M32;
    end else begin
      sum = ua + ub;  m_cy[ch] = (sum >= M32); bpv = ub;
    end
    if (sum < 0) sum += M32;
    m_res[ch] = 32'(sum % M32);
    sa   = (ua  >= 64'sd2147483648) ? ua  - M32 : ua;
    sbp  = (bpv >= 64'sd2147483648) ? bpv - M32 : bpv;
    ssum = sa + sbp;
    m_ov[ch]   = (ssum > SMAX) || (ssum < SMIN);
    m_done[ch] = 1;
  endfunction

  function automatic logic [1:0] model_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
    int ch, off;
    ch  = int'(a[7:4]);
    off = int'(a[3:2]);
    if (ch >= NCH || off == 2) return 2'b10;
    case (off)
      0: if (s != 0) begin m_opa[ch] = merge32(m_opa[ch], d, s); m_done[ch] = 0; end
      1: if (s != 0) begin m_opb[ch] = merge32(m_opb[ch], d, s); model_compute(ch); end
      default: if (s[0]) begin m_sub[ch] = d[0]; m_done[ch] = 0; end
    endcase
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(logic [7:0] a);
    int ch, off;
    ch  = int'(a[7:4]);
    off = int'(a[3:2]);
    if (ch >= NCH) return {2'b10, 32'h0};
    case (off)
      0:       return {2'b00, m_opa[ch]};
      1:       return {2'b00, m_opb[ch]};
      2:       return {2'b00, m_res[ch]};
      default: return {2'b00, 28'h0, m_done[ch], m_ov[ch], m_cy[ch], m_sub[ch]};
    endcase
  endfunction

  // ------------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      chk("b_expected", 64'(bq.size() != 0), 64'd1);
      if (bq.size() != 0) chk("bresp", 64'(bresp), 64'(bq.pop_front()));
    end
    if (!rst && rvalid && rready) begin
      chk("r_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) chk("rresp_rdata", 64'({rresp, rdata}), 64'(rq.pop_front()));
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lag, input int bp, output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire, got;
    int t;
    aw_done = 0; w_done = 0; got = 0; t = 0; resp = 2'b11;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && t < 50) begin
      awvalid = !aw_done;
      wvalid  = !w_done && (t >= w_lag);
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      t++;
    end
    awvalid = 0; wvalid = 0;
    chk("write_handshake", 64'(aw_done && w_done), 64'd1);
    if (!(aw_done && w_done)) return;
    bq.push_back(model_write(a, d, s));
    bready = (bp == 0);
    t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (bvalid) got = 1;
      else begin @(posedge clk); #1; end
      t++;
    end
    chk("bvalid_arrives", 64'(got), 64'd1);
    if (!got) begin bready = 1; return; end
    resp = bresp;
    for (int i = 0; i < bp; i++) begin
      chk("b_hold_valid", 64'(bvalid), 64'd1);
      chk("b_hold_resp", 64'(bresp), 64'(resp));
      chk("b_hold_readies", 64'({awready, wready}), 64'd0);
      @(posedge clk); #1;
      if (i == bp - 1) bready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("b_completed", 64'(bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, input int bp,
                          output logic [31:0] d, output logic [1:0] resp);
    bit fire, got;
    int t;
    fire = 0; got = 0; t = 0; d = '0; resp = 2'b11;
    rready = (bp == 0);
    araddr = a; arvalid = 1;
    while (!fire && t < 50) begin
      @(negedge clk);
      fire = arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 0;
    chk("ar_handshake", 64'(fire), 64'd1);
    if (!fire) begin rready = 1; return; end
    rq.push_back(model_read(a));
    t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if (rvalid) got = 1;
      else begin @(posedge clk); #1; end
      t++;
    end
    chk("rvalid_arrives", 64'(got), 64'd1);
    if (!got) begin rready = 1; return; end
    d = rdata; resp = rresp;
    for (int i = 0; i < bp; i++) begin
      chk("r_hold_valid", 64'(rvalid), 64'd1);
      chk("r_hold_data", 64'({rresp, rdata}), 64'({resp, d}));
      chk("r_hold_arready", 64'(arready), 64'd0);
      @(posedge clk); #1;
      if (i == bp - 1) rready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("r_completed", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // ----------------------------------------------------------------- sequence
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  a;
    logic [3:0]  s;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), 64'd0);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'({awready, wready, arready}), 64'h7);

    // Reset in the middle of a write: AW latched, W never sent
    axi_write(8'h00, 32'hDEAD0001, 4'hF, 0, 0, r);
    awaddr = 8'h00; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("midwrite_aw_latched", 64'(awready), 64'd0);
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_mid", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), 64'd0);
    model_reset(); bq.delete(); rq.delete();
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_reset_mid", 64'({awready, wready, arready}), 64'h7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_b_after_reset", 64'(bvalid), 64'd0);
      @(posedge clk); #1;
    end
    axi_read(8'h00, 0, d, r);
    chk("ch0_opa_after_reset", 64'(d), 64'd0);

    // Add with AW two cycles ahead of W
    axi_write(8'h10, 32'h7FFFFFFF, 4'hF, 2, 0, r);
    chk("ch1_opa_bresp", 64'(r), 64'd0);
    axi_write(8'h14, 32'h00000001, 4'hF, 0, 0, r);
    chk("ch1_opb_bresp", 64'(r), 64'd0);
    axi_read(8'h18, 0, d, r);
    chk("ch1_result", 64'(d), 64'h80000000);
    axi_read(8'h1C, 0, d, r);
    chk("ch1_status", 64'(d), 64'hC);

    // Subtract with borrow
    axi_write(8'h2C, 32'h1, 4'hF, 0, 0, r);
    axi_write(8'h20, 32'h3, 4'hF, 0, 0, r);
    axi_write(8'h24, 32'h5, 4'hF, 1, 0, r);
    axi_read(8'h28, 0, d, r);
    chk("ch2_result", 64'(d), 64'hFFFFFFFE);
    axi_read(8'h2C, 0, d, r);
    chk("ch2_status", 64'(d), 64'hB);
    axi_write(8'h20, 32'h7, 4'hF, 0, 0, r);
    axi_read(8'h2C, 0, d, r);
    chk("ch2_done_cleared", 64'(d), 64'h3);

    // Byte strobes, then a compute on ch0
    axi_write(8'h00, 32'h11223344, 4'hF, 0, 0, r);
    axi_write(8'h00, 32'hAABBCCDD, 4'h5, 0, 0, r);
    axi_read(8'h00, 0, d, r);
    chk("ch0_strobe_merge", 64'(d), 64'h11BB33DD);
    axi_write(8'h04, 32'h1, 4'hF, 0, 0, r);

    // Illegal accesses
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    chk("write_result_slverr", 64'(r), 64'h2);
    axi_read(8'h08, 0, d, r);
    chk("ch0_result_kept", 64'(d), 64'h11BB33DE);
    axi_read(8'(NCH * 16), 0, d, r);
    chk("read_oob_resp", 64'({r, d}), 64'h2_0000_0000);

    // Wrap-around
    axi_write(8'h30, 32'hFFFFFFFF, 4'hF, 0, 0, r);
    axi_write(8'h34, 32'h1, 4'hF, 0, 0, r);
    axi_read(8'h38, 0, d, r);
    chk("ch3_wrap_result", 64'(d), 64'h0);
    axi_read(8'h3C, 0, d, r);
    chk("ch3_wrap_status", 64'(d), 64'hA);

    // Backpressure on B and R
    axi_write(8'h30, 32'h5A5A5A5A, 4'hF, 0, 5, r);
    chk("bp_write_resp", 64'(r), 64'd0);
    axi_read(8'h30, 5, d, r);
    chk("bp_read_data", 64'(d), 64'h5A5A5A5A);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      a = {4'($urandom_range(0, NCH)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        axi_write(a, $urandom, s, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 2 : 0, r);
      end else begin
        axi_read(a, ($urandom_range(0, 7) == 0) ? 2 : 0, d, r);
      end
    end

    repeat (3) @(posedge clk);
    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
